// File: rtl/addsub_arbiter_pkg.sv
// Shared types and constants for the add/sub arbiter slice.
// Holds the sequencer state encoding and the opcode values.
package addsub_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic OP_SUB = 1'b0;
    localparam logic OP_ADD = 1'b1;

endpackage

// File: rtl/addsub_core.sv
// Falling-edge registered 16-bit add/subtract with zero-extended result.
// Ports: clk, rst (sync, high), en, a, b, op (1=add) -> result.
module addsub_core
    import addsub_arbiter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [15:0]      a,
    input  logic [15:0]      b,
    input  logic             op,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] a_x;
    logic [WIDTH-1:0] b_x;

    assign a_x = {{(WIDTH-16){1'b0}}, a};
    assign b_x = {{(WIDTH-16){1'b0}}, b};

    // Subtraction wraps modulo 2^WIDTH.
    always_ff @(negedge clk) begin
        if (rst) begin
            result <= '0;
        end else if (en) begin
            unique case (op)
                OP_ADD: result <= a_x + b_x;
                OP_SUB: result <= a_x - b_x;
                default: result <= a_x + b_x;
            endcase
        end
    end

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one add/sub unit among NREQ requesters.
// Ports: req_valid/ready/a/b/op per requester; rsp_valid/ready/id/data; busy.
module addsub_arbiter
    import addsub_arbiter_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int WIDTH = 32,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*16-1:0] req_a,
    input  logic [NREQ*16-1:0] req_b,
    input  logic [NREQ-1:0]    req_op,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output logic [WIDTH-1:0]   rsp_data,
    output logic               busy
);

    localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);
    localparam logic [IDW-1:0] LAST = IDW'(NREQ-1);

    state_t state;
    state_t state_n;

    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  id_q;
    logic [IDW-1:0]  gnt_id;
    logic [NREQ-1:0] gnt_oh;
    logic            gnt_any;
    logic [IDW:0]    scan;
    logic [15:0]     a_q;
    logic [15:0]     b_q;
    logic            op_q;
    logic [15:0]     a_arr [NREQ];
    logic [15:0]     b_arr [NREQ];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            a_arr[i] = req_a[16*i +: 16];
            b_arr[i] = req_b[16*i +: 16];
        end
    end

    // First valid requester at or above rr_ptr, wrapping.
    always_comb begin
        gnt_oh  = '0;
        gnt_id  = '0;
        gnt_any = 1'b0;
        scan    = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (scan >= NREQ_W) begin
                scan = scan - NREQ_W;
            end
            if (!gnt_any && req_valid[scan[IDW-1:0]]) begin
                gnt_any = 1'b1;
                gnt_id  = scan[IDW-1:0];
                gnt_oh[scan[IDW-1:0]] = 1'b1;
            end
        end
    end

    always_comb begin
        state_n   = state;
        req_ready = '0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        unique case (state)
            ST_IDLE: begin
                busy      = 1'b0;
                req_ready = gnt_oh;
                if (gnt_any) begin
                    state_n = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_n = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            rr_ptr <= '0;
            id_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= OP_SUB;
        end else begin
            state <= state_n;
            if (state == ST_IDLE && gnt_any) begin
                a_q    <= a_arr[gnt_id];
                b_q    <= b_arr[gnt_id];
                op_q   <= req_op[gnt_id];
                id_q   <= gnt_id;
                rr_ptr <= (gnt_id == LAST) ? '0 : gnt_id + IDW'(1);
            end
        end
    end

    // Enabled only in EXEC, so the result holds through RESP.
    addsub_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .en    (state == ST_EXEC),
        .a     (a_q),
        .b     (b_q),
        .op    (op_q),
        .result(rsp_data)
    );

    assign rsp_id = id_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Self-checking bench for addsub_arbiter.
// Directed table, corner sequences and random traffic vs a reference model.
module tb_addsub_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 32;
    localparam int IDW   = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*16-1:0] req_a;
    logic [NREQ*16-1:0] req_b;
    logic [NREQ-1:0]   req_op;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [WIDTH-1:0]  rsp_data;
    logic              busy;

    always #5 clk = ~clk;

    addsub_arbiter #(
        .NREQ (NREQ),
        .WIDTH(WIDTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .req_op   (req_op),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id   (rsp_id),
        .rsp_data (rsp_data),
        .busy     (busy)
    );

    typedef struct {
        int          req;
        logic [15:0] a;
        logic [15:0] b;
        logic        op;
        int          eid;
        logic [31:0] edata;
    } vec_t;

    vec_t vt [6];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model: one outstanding op, phase 0 = computing, 1 = result out.
    bit          chk_en = 0;
    bit          busy_m = 0;
    int          ph     = 0;
    int          ptr    = 0;
    int          m_id   = 0;
    logic [31:0] m_data = '0;
    int          acc_g  = -1;

    int gl_id  [$];
    int gl_cyc [$];

    function automatic int arb(int p, logic [3:0] v);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic int oh_idx(logic [3:0] v);
        for (int k = 0; k < NREQ; k++) begin
            if (v[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [31:0] calc(logic [15:0] a, logic [15:0] b, logic op);
        longint r;
        r = op ? (longint'(a) + longint'(b)) : (longint'(a) - longint'(b));
        return r[31:0];
    endfunction

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    task automatic cycle;
        int g;
        logic [3:0] er;
        #1;
        if (chk_en) begin
            g  = busy_m ? -1 : arb(ptr, req_valid);
            er = (g < 0) ? 4'b0 : 4'(1 << g);
            chk("req_ready", 64'(req_ready), 64'(er));
            chk("busy", 64'(busy), 64'(busy_m));
            chk("rsp_valid", 64'(rsp_valid), 64'(busy_m && ph == 1));
            if (busy_m && ph == 1) begin
                chk("rsp_id", 64'(rsp_id), 64'(m_id));
                chk("rsp_data", 64'(rsp_data), 64'(m_data));
            end
            if (req_ready != 0) begin
                gl_id.push_back(oh_idx(req_ready));
                gl_cyc.push_back(cyc);
            end
        end
        @(negedge clk);
        cyc++;
        acc_g = -1;
        if (rst) begin
            busy_m = 0;
            ph     = 0;
            ptr    = 0;
            m_id   = 0;
            m_data = '0;
        end else if (!busy_m) begin
            g = arb(ptr, req_valid);
            if (g >= 0) begin
                busy_m = 1;
                ph     = 0;
                m_id   = g;
                m_data = calc(req_a[16*g +: 16], req_b[16*g +: 16], req_op[g]);
                ptr    = (g + 1) % NREQ;
                acc_g  = g;
            end
        end else if (ph == 0) begin
            ph = 1;
        end else if (rsp_ready) begin
            busy_m = 0;
        end
        chk_en = 1;
        #1;
    endtask

    task automatic wait_idle;
        int b;
        b = 0;
        req_valid = '0;
        rsp_ready = 1'b1;
        while (busy_m && b < 20) begin
            cycle();
            b++;
        end
        chk("idle_timeout", 64'(busy_m), 64'(0));
    endtask

    task automatic load(int i, logic [15:0] a, logic [15:0] b, logic op);
        req_a[16*i +: 16] = a;
        req_b[16*i +: 16] = b;
        req_op[i] = op;
    endtask

    initial begin
        int nv;
        logic [31:0] d0;
        logic [IDW-1:0] id0;

        vt[0] = '{2, 16'hFFFF, 16'hFFFF, 1'b1, 2, 32'h0001_FFFE};
        vt[1] = '{1, 16'h0005, 16'h0007, 1'b0, 1, 32'hFFFF_FFFE};
        vt[2] = '{0, 16'h0000, 16'h0000, 1'b0, 0, 32'h0000_0000};
        vt[3] = '{3, 16'h0000, 16'hFFFF, 1'b0, 3, 32'hFFFF_0001};
        vt[4] = '{3, 16'hFFFF, 16'h0001, 1'b1, 3, 32'h0001_0000};
        vt[5] = '{0, 16'h1234, 16'h1234, 1'b0, 0, 32'h0000_0000};

        rst       = 1'b1;
        req_valid = 4'hF;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = 1'b0;

        // Reset held for two edges with all requesters valid.
        cycle();
        cycle();
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_rsp_id", 64'(rsp_id), 64'(0));
        chk("rst_rsp_data", 64'(rsp_data), 64'(0));

        for (int i = 0; i < NREQ; i++) begin
            load(i, 16'(i * 1111 + 7), 16'(i * 300 + 3), i[0]);
        end
        rst       = 1'b0;
        rsp_ready = 1'b1;
        #1;
        chk("first_grant", 64'(req_ready), 64'(4'b0001));

        // Fairness with all requesters continuously valid.
        gl_id.delete();
        gl_cyc.delete();
        for (int n = 0; n < 20; n++) cycle();
        chk("fair_count", 64'(gl_id.size() >= 6), 64'(1));
        if (gl_id.size() >= 6) begin
            chk("fair_0", 64'(gl_id[0]), 64'(0));
            chk("fair_1", 64'(gl_id[1]), 64'(1));
            chk("fair_2", 64'(gl_id[2]), 64'(2));
            chk("fair_3", 64'(gl_id[3]), 64'(3));
            chk("fair_4", 64'(gl_id[4]), 64'(0));
            chk("fair_5", 64'(gl_id[5]), 64'(1));
        end

        // Directed single operations.
        for (int i = 0; i < 6; i++) begin
            wait_idle();
            load(vt[i].req, vt[i].a, vt[i].b, vt[i].op);
            req_valid[vt[i].req] = 1'b1;
            cycle();
            req_valid = '0;
            cycle();
            chk("vec_valid", 64'(rsp_valid), 64'(1));
            chk("vec_id", 64'(rsp_id), 64'(vt[i].eid));
            chk("vec_data", 64'(rsp_data), 64'(vt[i].edata));
            cycle();
            chk("vec_done", 64'(busy), 64'(0));
        end

        // Single requester held valid: one grant every 3 cycles.
        wait_idle();
        load(2, 16'h00AA, 16'h0055, 1'b1);
        req_valid = 4'b0100;
        gl_id.delete();
        gl_cyc.delete();
        for (int n = 0; n < 10; n++) cycle();
        chk("solo_count", 64'(gl_id.size() >= 3), 64'(1));
        if (gl_id.size() >= 3) begin
            chk("solo_id", 64'(gl_id[0]), 64'(2));
            chk("solo_gap1", 64'(gl_cyc[1] - gl_cyc[0]), 64'(3));
            chk("solo_gap2", 64'(gl_cyc[2] - gl_cyc[1]), 64'(3));
        end

        // Backpressure: five edges with rsp_ready low during RESP.
        wait_idle();
        load(1, 16'h4321, 16'h1234, 1'b0);
        req_valid = 4'b0010;
        cycle();
        req_valid = 4'hF;
        rsp_ready = 1'b0;
        cycle();
        d0  = rsp_data;
        id0 = rsp_id;
        chk("bp_valid0", 64'(rsp_valid), 64'(1));
        chk("bp_data0", 64'(rsp_data), 64'(32'h0000_30ED));
        for (int n = 0; n < 5; n++) begin
            cycle();
            chk("bp_valid", 64'(rsp_valid), 64'(1));
            chk("bp_data", 64'(rsp_data), 64'(d0));
            chk("bp_id", 64'(rsp_id), 64'(id0));
            chk("bp_ready", 64'(req_ready), 64'(0));
        end
        rsp_ready = 1'b1;
        cycle();
        chk("bp_done", 64'(busy), 64'(0));
        chk("bp_done_valid", 64'(rsp_valid), 64'(0));

        // Reset during EXEC discards the operation.
        wait_idle();
        load(3, 16'h0101, 16'h0202, 1'b1);
        req_valid = 4'b1000;
        cycle();
        req_valid = '0;
        rst = 1'b1;
        cycle();
        chk("rx_valid", 64'(rsp_valid), 64'(0));
        chk("rx_busy", 64'(busy), 64'(0));
        rst = 1'b0;
        req_valid = 4'hF;
        #1;
        chk("rx_ptr", 64'(req_ready), 64'(4'b0001));
        req_valid = '0;
        nv = 0;
        for (int n = 0; n < 6; n++) begin
            cycle();
            if (rsp_valid) nv++;
        end
        chk("rx_discard", 64'(nv), 64'(0));

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            if (acc_g >= 0) req_valid[acc_g] = 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        load(i, 16'($urandom), 16'($urandom), 1'($urandom));
                        req_valid[i] = 1'b1;
                    end
                end else if ($urandom_range(0, 19) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        rst = 1'b0;
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
